// File: rtl/fft_run_sched.sv
// Frame scheduler for the FFT engine: captures one frame into the sample RAM, launches the
// engine, waits for done, and arbitrates the single RAM port. FFT_CONT_RUN_EN enables free-running DONE->FILL.
module fft_run_sched #(
  parameter int N_LOG2     = 12,
  parameter int AW         = 12,
  parameter int DW         = 12,
  parameter int STARVE_MAX = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          run_req,
  input  logic          abort,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  output logic          fft_start,
  input  logic          fft_done,
  input  logic          fft_mreq,
  output logic          fft_mgnt,
  input  logic          disp_mreq,
  output logic          disp_mgnt,
  output logic [1:0]    mem_sel,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic [7:0]    frame_cnt,
  output logic          ovf
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'((1 << N_LOG2) - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_LAUNCH, S_WAITLO, S_RUN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   fill_addr_q, fill_addr_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            ovf_q, ovf_d;
  logic            cap_gnt, fft_gnt, disp_gnt;
  logic            in_fill, fill_entry;

  // One owner per cycle; display starvation override only applies while the engine owns the RAM.
  always_comb begin
    cap_gnt  = 1'b0;
    fft_gnt  = 1'b0;
    disp_gnt = 1'b0;
    case (state_q)
      S_FILL: begin
        if (buf_full_q) cap_gnt  = 1'b1;
        else            disp_gnt = disp_mreq;
      end
      S_WAITLO, S_RUN: begin
        if (disp_mreq && starve_q == STARVE_LIM) disp_gnt = 1'b1;
        else if (fft_mreq)                      fft_gnt  = 1'b1;
        else                                    disp_gnt = disp_mreq;
      end
      default: disp_gnt = disp_mreq;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fft_start = 1'b0;
    case (state_q)
      S_IDLE:   if (run_req) state_d = S_FILL;
      S_FILL:   if (cap_gnt && fill_addr_q == LAST_ADDR) state_d = S_LAUNCH;
      S_LAUNCH: begin
        fft_start = 1'b1;
        state_d   = S_WAITLO;
      end
      S_WAITLO: if (!fft_done) state_d = S_RUN;
      S_RUN:    if (fft_done)  state_d = S_DONE;
      S_DONE: begin
`ifdef FFT_CONT_RUN_EN
        state_d = S_FILL;
`else
        state_d = S_IDLE;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      fft_start = 1'b0;
    end
  end

  assign in_fill    = (state_q == S_FILL) && !abort;
  assign fill_entry = (state_d == S_FILL) && (state_q != S_FILL);

  always_comb begin
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    fill_addr_d = fill_addr_q;
    ovf_d       = ovf_q;
    if (in_fill) begin
      if (cap_gnt) begin
        buf_full_d  = 1'b0;
        fill_addr_d = fill_addr_q + 1'b1;
      end
      if (smp_valid) begin
        if (!buf_full_q || cap_gnt) begin
          buf_full_d = 1'b1;
          buf_d      = smp_data;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    // Leftover samples never carry into the next frame.
    if (state_d != S_FILL) begin
      buf_full_d  = 1'b0;
      fill_addr_d = '0;
    end
    if (fill_entry) ovf_d = 1'b0;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == S_DONE && !abort) frame_cnt_d = frame_cnt_q + 8'd1;
    starve_d = '0;
    if (disp_mreq && !disp_gnt)
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      fill_addr_q <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      starve_q    <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      starve_q    <= starve_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fft_mgnt  = fft_gnt;
  assign disp_mgnt = disp_gnt;
  assign mem_sel   = cap_gnt ? 2'd1 : fft_gnt ? 2'd2 : disp_gnt ? 2'd3 : 2'd0;
  assign mem_we    = cap_gnt;
  assign mem_addr  = fill_addr_q;
  assign mem_wdata = buf_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign ovf       = ovf_q;

endmodule
